// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed NDIG-digit 7-segment driver.
// A packed hex value (plus decimal points and the leading-zero flag) is
// snapshotted once per frame, so an update never tears a frame. Strobes and
// segments are active-low and registered.
// Optional feature: define SEG_BLINK_EN to add the per-digit blink port and
// the frame-based blink phase counter.
module seg_scan_mux #(
    parameter int NDIG         = 4,
    parameter int DIV          = 10000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [4*NDIG-1:0]   num,
    input  logic [NDIG-1:0]     dp,
    input  logic                lz_blank,
`ifdef SEG_BLINK_EN
    input  logic [NDIG-1:0]     blink,
`endif
    output logic [NDIG-1:0]     dig,
    output logic [7:0]          seg
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [4*NDIG-1:0] r_num_s;
    logic [NDIG-1:0]   r_dp_s;
    logic              r_lz_s;

    logic              w_tick;
    logic              w_wrap;
    logic              w_load;
    logic [3:0]        w_nib;
    logic [NDIG-1:0]   w_blank;
    logic [7:0]        w_seg;

    // Segment pattern g..a, active-low.
    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h40;  4'h1: font = 7'h79;
            4'h2: font = 7'h24;  4'h3: font = 7'h30;
            4'h4: font = 7'h19;  4'h5: font = 7'h12;
            4'h6: font = 7'h02;  4'h7: font = 7'h78;
            4'h8: font = 7'h00;  4'h9: font = 7'h10;
            4'hA: font = 7'h08;  4'hB: font = 7'h03;
            4'hC: font = 7'h46;  4'hD: font = 7'h21;
            4'hE: font = 7'h06;  default: font = 7'h0E;
        endcase
    endfunction

    assign w_tick = en && (r_cnt == CW'(DIV - 1));
    assign w_wrap = w_tick && (r_idx == IW'(NDIG - 1));
    // While disabled the snapshot tracks the inputs so re-enable shows fresh data.
    assign w_load = !en || w_wrap;
    assign w_nib  = r_num_s[{r_idx, 2'b00} +: 4];

    // Prescaler and digit index; both parked at 0 while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (!en) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Per-frame snapshot of the displayed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_s <= '0;
            r_dp_s  <= '0;
            r_lz_s  <= 1'b0;
        end else if (w_load) begin
            r_num_s <= num;
            r_dp_s  <= dp;
            r_lz_s  <= lz_blank;
        end
    end

    // Digit i is blank when it and every higher nibble are zero (never digit 0).
    always_comb begin
        logic v_zero;
        v_zero  = 1'b1;
        w_blank = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            v_zero     = v_zero && (r_num_s[4*i +: 4] == 4'h0);
            w_blank[i] = r_lz_s && v_zero && (i != 0);
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0]   r_bcnt;
    logic            r_phase;
    logic [NDIG-1:0] r_blink_s;

    // Blink mask is captured together with the value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_blink_s <= '0;
        else if (w_load) r_blink_s <= blink;
    end

    // Frame counter; phase flips each BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (!en) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    // Segment pattern for the current slot; blinked digits go fully dark.
    always_comb begin
        w_seg = {~r_dp_s[r_idx], w_blank[r_idx] ? 7'h7F : font(w_nib)};
        if (r_phase && r_blink_s[r_idx]) w_seg = 8'hFF;
    end
`else
    // Segment pattern for the current slot.
    always_comb begin
        w_seg = {~r_dp_s[r_idx], w_blank[r_idx] ? 7'h7F : font(w_nib)};
    end
`endif

    // Registered pin drivers; dark whenever disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig <= '1;
            seg <= 8'hFF;
        end else if (!en) begin
            dig <= '1;
            seg <= 8'hFF;
        end else begin
            dig <= ~(NDIG'(1) << r_idx);
            seg <= w_seg;
        end
    end

endmodule
